// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight GPR/FPR writes with forwarding countdowns
// and holds decode on RAW, WAW and single-outstanding-load conflicts.
module hazard_scoreboard #(
  parameter  int NREG    = 32,
  parameter  int REG_W   = 5,
  parameter  int MAX_LAT = 15,
  localparam int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic [2:0]       dec_rd_en,
  input  logic [2:0]       dec_rd_fp,
  input  logic [REG_W-1:0] dec_rd_d,
  input  logic [REG_W-1:0] dec_rd_s,
  input  logic [REG_W-1:0] dec_rd_t,
  input  logic             dec_wr_en,
  input  logic             dec_wr_fp,
  input  logic [REG_W-1:0] dec_wr_reg,
  input  logic [CNT_W-1:0] dec_wr_lat,
  input  logic             dec_wr_var,
  input  logic             mem_done,
  input  logic             mem_done_fp,
  input  logic [REG_W-1:0] mem_done_reg,
  output logic             stall,
  output logic             issue,
  output logic             var_busy
);

  localparam logic [CNT_W:0] MAX_CNT_X = (CNT_W + 1)'(MAX_LAT);

  // Index 0 of each array is the GPR file, index 1 the FPR file.
  logic [NREG-1:0]  r_pend [2];
  logic [NREG-1:0]  r_var  [2];
  logic [CNT_W-1:0] r_cnt  [2][NREG];
  logic             r_var_busy;

  logic [NREG-1:0]  w_pend_nxt [2];
  logic [NREG-1:0]  w_var_nxt  [2];
  logic [CNT_W-1:0] w_cnt_nxt  [2][NREG];
  logic             w_var_busy_nxt;

  logic [REG_W-1:0] w_src_idx [3];
  logic [2:0]       w_src_rdy;
  logic [CNT_W-1:0] w_new_lat;
  logic             w_wr_track;
  logic             w_tgt_pend;
  logic             w_tgt_var;
  logic [CNT_W-1:0] w_tgt_cnt;
  logic             w_raw;
  logic             w_waw;
  logic             w_struct;
  logic             w_load;

  assign w_src_idx[0] = dec_rd_d;
  assign w_src_idx[1] = dec_rd_s;
  assign w_src_idx[2] = dec_rd_t;

  // A variable-latency write has no countdown; it orders as latency 0 against older writes.
  always_comb begin
    w_new_lat = dec_wr_lat;
    if ({1'b0, dec_wr_lat} > MAX_CNT_X) begin
      w_new_lat = MAX_CNT_X[CNT_W-1:0];
    end
    if (dec_wr_var) begin
      w_new_lat = '0;
    end
  end

  assign w_wr_track = dec_wr_en & (dec_wr_fp | (dec_wr_reg != '0));

  always_comb begin
    w_raw     = 1'b0;
    w_src_rdy = '1;
    for (int unsigned k = 0; k < 3; k++) begin
      w_src_rdy[k] = ~r_pend[dec_rd_fp[k]][w_src_idx[k]]
                   | ((r_cnt[dec_rd_fp[k]][w_src_idx[k]] == '0) & ~r_var[dec_rd_fp[k]][w_src_idx[k]]);
      if (!dec_rd_fp[k] && (w_src_idx[k] == '0)) begin
        w_src_rdy[k] = 1'b1;
      end
      if (dec_rd_en[k] && !w_src_rdy[k]) begin
        w_raw = 1'b1;
      end
    end
  end

  assign w_tgt_pend = r_pend[dec_wr_fp][dec_wr_reg];
  assign w_tgt_var  = r_var[dec_wr_fp][dec_wr_reg];
  assign w_tgt_cnt  = r_cnt[dec_wr_fp][dec_wr_reg];

  assign w_waw    = w_wr_track & w_tgt_pend & (w_tgt_var | (w_tgt_cnt > w_new_lat));
  assign w_struct = dec_wr_var & r_var_busy;

  assign stall    = dec_valid & (w_raw | w_waw | w_struct);
  assign issue    = dec_valid & ~stall & ~flush;
  assign w_load   = issue & w_wr_track;
  assign var_busy = r_var_busy;

  // Priority per entry: issue load, then mem_done on var entries, then flush, then countdown.
  always_comb begin : p_next
    logic w_hit_wr;
    logic w_hit_md;
    w_hit_wr   = 1'b0;
    w_hit_md   = 1'b0;
    w_pend_nxt = r_pend;
    w_var_nxt  = r_var;
    w_cnt_nxt  = r_cnt;
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        w_hit_wr = w_load && (dec_wr_fp == 1'(f)) && (dec_wr_reg == REG_W'(i));
        w_hit_md = mem_done && (mem_done_fp == 1'(f)) && (mem_done_reg == REG_W'(i));
        if (w_hit_wr) begin
          w_pend_nxt[f][i] = 1'b1;
          w_var_nxt[f][i]  = dec_wr_var;
          w_cnt_nxt[f][i]  = w_new_lat;
        end else if (r_var[f][i]) begin
          if (w_hit_md) begin
            w_pend_nxt[f][i] = 1'b0;
            w_var_nxt[f][i]  = 1'b0;
          end
        end else if (flush) begin
          w_pend_nxt[f][i] = 1'b0;
          w_cnt_nxt[f][i]  = '0;
        end else if (r_pend[f][i]) begin
          if (r_cnt[f][i] != '0) begin
            w_cnt_nxt[f][i] = r_cnt[f][i] - CNT_W'(1);
          end else begin
            w_pend_nxt[f][i] = 1'b0;
          end
        end
      end
    end
    w_var_busy_nxt = (|w_var_nxt[0]) | (|w_var_nxt[1]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned f = 0; f < 2; f++) begin
        r_pend[f] <= '0;
        r_var[f]  <= '0;
        for (int unsigned i = 0; i < NREG; i++) begin
          r_cnt[f][i] <= '0;
        end
      end
      r_var_busy <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_var      <= w_var_nxt;
      r_cnt      <= w_cnt_nxt;
      r_var_busy <= w_var_busy_nxt;
    end
  end

endmodule
